ling_serial_addsub: RTL and testbench
=====================================

// Module: ling_serial_addsub
// PURPOSE
//  Multi-cycle add/subtract unit for the FPU datapath. Processes one K-bit Ling slice per clock,
//  keeping a registered carry between slices. Trades latency for area against the single-cycle
//  hierarchical adders. Valid/ready handshakes on both sides; computes A+B or A-B (A + ~B + 1).
// PARAMETERS
//  N  8  operand/result width; any N>=1; last slice is N-(NB-1)*K bits wide
//  K  4  slice width in bits, fixed (from package); NB = ceil(N/K) slices
// PORTS
//  CLOCK_50   in   1  clock, rising edge
//  RESET_N    in   1  asynchronous reset, active low
//  in_valid   in   1  operands/op valid
//  in_ready   out  1  unit idle, can accept
//  op_sub     in   1  1: A-B, 0: A+B
//  A          in   N  operand A (unsigned/two's complement)
//  B          in   N  operand B
//  out_valid  out  1  result valid
//  out_ready  in   1  consumer accepts result
//  D          out  N  result, modulo 2^N
//  cout       out  1  raw carry out of bit N-1 (sub: 1 = no borrow)
//  borrow     out  1  op_sub & ~cout (unsigned A<B); 0 for add
//  zero       out  1  D == 0
//  ovf        out  1  signed overflow (LING_ADDSUB_FLAGS_EN only, else 0)
//  lt         out  1  signed A<B for sub (LING_ADDSUB_FLAGS_EN only, else 0)
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=0; D, cout, borrow, zero, ovf, lt = 0; slice idx=0.
//  FSM IDLE->RUN->DONE->IDLE.
//  IDLE: in_ready=1. On in_valid: latch A, B^{N{op_sub}}, op_sub; carry_reg=op_sub; idx=0; ->RUN.
//  RUN: in_ready=0. Each cycle, slice idx: D[idx*K +: w] = slice sum(carry_reg); carry_reg=slice cout;
//   idx++. After slice NB-1: latch cout, borrow, zero, flags; ->DONE. RUN lasts exactly NB cycles.
//  DONE: out_valid=1; D and flags held stable while out_ready=0. On out_ready: ->IDLE next cycle.
//  Latency: accept edge at cycle 0 -> out_valid high at cycle NB+1. Max throughput 1 op / NB+2 cycles.
//  Operands sampled only on the accept edge; later input changes have no effect.
//   in_valid outside IDLE is ignored, never queued.
//  Partial last slice: upper pad bits are forced 0 on both operands. cout comes from bit N-1,
//   not from the pad.
//  D is updated per slice during RUN and is only meaningful while out_valid=1.
//  Reset asserted mid-RUN/DONE: immediate return to reset values; in-flight op discarded, no output.
//  out_ready is ignored while out_valid=0.
// CONFIGURATION
//  `LING_ADDSUB_FLAGS_EN defined: ovf = carry into MSB ^ cout (latched in the last slice);
//   lt = op_sub & (D[N-1]^ovf). Both latched with D and valid in DONE.
//  Not defined: ovf, lt tied to 0. No MSB-carry tap is kept.
//  Handshake and latency identical in both builds.
// STRUCTURE
//  Package fpu_arith_pkg: localparam LING_K=4; FSM state encoding (ST_IDLE, ST_RUN, ST_DONE);
//   function nb_slices(N).
//  Sub-module ling_slice_add (combinational): K-bit Ling slice with width parameter W<=K;
//   inputs a, b, cin; outputs s, cout, c_msb (carry into bit W-1).
//  Top level contains: FSM, idx counter ($clog2(NB)+1 bits), operand/result registers, carry register.
// TESTING
//  N=8 sub A=8'h05 B=8'h03 -> D=8'h02 cout=1 borrow=0 zero=0; out_valid exactly 3 cycles
//   after accept.
//  N=8 sub A=8'h03 B=8'h05 -> D=8'hFE cout=0 borrow=1. Add A=8'hFF B=8'h01 -> D=8'h00 cout=1 zero=1.
//  N=10 (partial slice) add A=10'h3FF B=10'h001 -> D=0 cout=1; sub A=10'h200 B=10'h001 -> D=10'h1FF.
//  Backpressure: out_ready=0 for 5 cycles in DONE -> D/flags stable, in_ready=0,
//   in_valid pulse ignored.
//  RESET_N low during 2nd RUN cycle -> out_valid=0, in_ready=1 at once; next op gives correct result.
//  FLAGS_EN, N=8 sub A=8'h80 B=8'h01 -> D=8'h7F ovf=1 lt=1; without macro, ovf=lt=0.

Source files
------------

// File: rtl/fpu_arith_pkg.sv
// ---------------------------------------------------------------------------
// fpu_arith_pkg
// Shared constants and types for the serial FPU arithmetic blocks:
//   LING_K      : Ling slice width in bits
//   state_t     : add/sub sequencer states (ST_IDLE, ST_RUN, ST_DONE)
//   nb_slices() : number of LING_K-bit slices needed to cover an n-bit operand
// ---------------------------------------------------------------------------
package fpu_arith_pkg;

  localparam int LING_K = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nb_slices(input int n);
    return (n + LING_K - 1) / LING_K;
  endfunction

endpackage

// File: rtl/ling_slice_add.sv
// ---------------------------------------------------------------------------
// ling_slice_add
// Combinational W-bit Ling adder slice (W <= LING_K).
// Ports:
//   a, b   in  W  slice operands
//   cin    in  1  carry into bit 0
//   s      out W  slice sum
//   cout   out 1  carry out of bit W-1
//   c_msb  out 1  carry into bit W-1 (used for signed-overflow detection)
// ---------------------------------------------------------------------------
module ling_slice_add
  import fpu_arith_pkg::*;
#(
  parameter int W = LING_K
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W-1:0] w_g;  // generate
  logic [W-1:0] w_t;  // transmit (a | b), Ling's propagate term
  logic [W-1:0] w_x;  // half sum
  logic [W-1:0] w_h;  // Ling pseudo-carry
  logic [W:0]   w_c;  // real carries, w_c[i] = carry into bit i

  // Ling pseudo-carry h[i] = g[i] | c[i]; the real carry is recovered as
  // c[i+1] = t[i] & h[i]. The recurrence drops one AND term per stage
  // compared with the classic g/p carry chain.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a value on
    // all paths first, otherwise synthesis infers a latch.
    w_g    = a & b;
    w_t    = a | b;
    w_x    = a ^ b;
    w_h    = '0;
    w_c    = '0;
    w_c[0] = cin;
    w_h[0] = w_g[0] | cin;
    w_c[1] = w_t[0] & w_h[0];
    for (int i = 1; i < W; i++) begin
      w_h[i]   = w_g[i] | (w_t[i-1] & w_h[i-1]);
      w_c[i+1] = w_t[i] & w_h[i];
    end
  end

  assign s     = w_x ^ w_c[W-1:0];
  assign cout  = w_c[W];
  assign c_msb = w_c[W-1];

endmodule

// File: rtl/ling_serial_addsub.sv
// ---------------------------------------------------------------------------
// ling_serial_addsub
// Multi-cycle add/subtract unit: one LING_K-bit Ling slice per clock with a
// registered carry between slices. Computes A+B or A-B (A + ~B + 1).
// Optional feature macro: LING_ADDSUB_FLAGS_EN (signed ovf / lt flags);
// when undefined ovf and lt are tied to 0.
// Ports:
//   CLOCK_50   in  1  clock, rising edge
//   RESET_N    in  1  asynchronous reset, active low
//   in_valid   in  1  operands/op valid
//   in_ready   out 1  unit idle, can accept
//   op_sub     in  1  1: A-B, 0: A+B
//   A, B       in  N  operands
//   out_valid  out 1  result valid
//   out_ready  in  1  consumer accepts result
//   D          out N  result modulo 2^N
//   cout       out 1  carry out of bit N-1 (sub: 1 = no borrow)
//   borrow     out 1  op_sub & ~cout
//   zero       out 1  D == 0
//   ovf        out 1  signed overflow (flags build only)
//   lt         out 1  signed A<B for sub (flags build only)
// ---------------------------------------------------------------------------
module ling_serial_addsub
  import fpu_arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         cout,
  output logic         borrow,
  output logic         zero,
  output logic         ovf,
  output logic         lt
);

  localparam int NB     = nb_slices(N);
  localparam int W_LAST = N - (NB - 1) * LING_K;
  localparam int IW     = $clog2(NB) + 1;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;        // already conditionally inverted for subtract
  logic           r_op_sub;
  logic           r_carry;
  logic [N-1:0]   r_d;
  logic           r_cout;
  logic           r_borrow;
  logic           r_zero;
  logic           r_in_ready;
  logic           r_out_valid;

  logic              w_last;
  logic [W_LAST-1:0] w_s_last;
  logic              w_cout_last;
  logic [N-1:0]      w_d_final;

  logic [LING_K-1:0] w_a_full;
  logic [LING_K-1:0] w_b_full;
  logic [LING_K-1:0] w_s_full;
  logic              w_cout_full;

  assign w_last = (r_idx == IW'(NB - 1));

  // Full-width slices 0..NB-2 share one adder; the operand slice is muxed
  // by r_idx. The (possibly narrower) last slice has its own adder so the
  // carry out is taken from bit N-1 directly, with no pad bits involved.
  if (NB > 1) begin : g_full
    always_comb begin
      w_a_full = '0;
      w_b_full = '0;
      for (int s = 0; s < NB - 1; s++) begin
        if (r_idx == IW'(s)) begin
          w_a_full = r_a[s*LING_K +: LING_K];
          w_b_full = r_b[s*LING_K +: LING_K];
        end
      end
    end

    ling_slice_add #(.W(LING_K)) u_slice_full (
      .a     (w_a_full),
      .b     (w_b_full),
      .cin   (r_carry),
      .s     (w_s_full),
      .cout  (w_cout_full),
      .c_msb ()
    );
  end else begin : g_no_full
    assign w_a_full    = '0;
    assign w_b_full    = '0;
    assign w_s_full    = '0;
    assign w_cout_full = 1'b0;
  end

`ifdef LING_ADDSUB_FLAGS_EN
  logic w_c_msb_last;
  logic w_ovf_next;
  logic r_ovf;
  logic r_lt;
`endif

  ling_slice_add #(.W(W_LAST)) u_slice_last (
    .a     (r_a[(NB-1)*LING_K +: W_LAST]),
    .b     (r_b[(NB-1)*LING_K +: W_LAST]),
    .cin   (r_carry),
    .s     (w_s_last),
    .cout  (w_cout_last),
`ifdef LING_ADDSUB_FLAGS_EN
    .c_msb (w_c_msb_last)
`else
    .c_msb ()
`endif
  );

`ifdef LING_ADDSUB_FLAGS_EN
  assign w_ovf_next = w_c_msb_last ^ w_cout_last;
`endif

  // Result as it will look after the last slice is written, so zero and
  // the sign bit can be latched on the same edge.
  always_comb begin
    w_d_final = r_d;
    w_d_final[(NB-1)*LING_K +: W_LAST] = w_s_last;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op_sub    <= 1'b0;
      r_carry     <= 1'b0;
      r_d         <= '0;
      r_cout      <= 1'b0;
      r_borrow    <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef LING_ADDSUB_FLAGS_EN
      r_ovf       <= 1'b0;
      r_lt        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= A;
            r_b        <= B ^ {N{op_sub}};
            r_op_sub   <= op_sub;
            r_carry    <= op_sub;   // the +1 of two's-complement negate
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_last) begin
            r_d[(NB-1)*LING_K +: W_LAST] <= w_s_last;
            r_cout      <= w_cout_last;
            r_borrow    <= r_op_sub & ~w_cout_last;
            r_zero      <= ~|w_d_final;
`ifdef LING_ADDSUB_FLAGS_EN
            r_ovf       <= w_ovf_next;
            r_lt        <= r_op_sub & (w_d_final[N-1] ^ w_ovf_next);
`endif
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            for (int s = 0; s < NB - 1; s++) begin
              if (r_idx == IW'(s)) r_d[s*LING_K +: LING_K] <= w_s_full;
            end
            r_carry <= w_cout_full;
            r_idx   <= r_idx + IW'(1);
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_idx       <= '0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign cout      = r_cout;
  assign borrow    = r_borrow;
  assign zero      = r_zero;
`ifdef LING_ADDSUB_FLAGS_EN
  assign ovf       = r_ovf;
  assign lt        = r_lt;
`else
  assign ovf       = 1'b0;
  assign lt        = 1'b0;
`endif

endmodule

// File: tb/tb_ling_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_ling_serial_addsub
// Drives an N=8 and an N=10 instance of ling_serial_addsub with directed and
// random operations and compares every result against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_ling_serial_addsub;

  logic clk;
  logic rst_n;

  logic       iv8, ir8, op8, ov8, ordy8, co8, bo8, ze8, ovf8, lt8;
  logic [7:0] a8, b8, d8;
  logic       iv10, ir10, op10, ov10, ordy10, co10, bo10, ze10, ovf10, lt10;
  logic [9:0] a10, b10, d10;

  int n_checks = 0;
  int n_fail   = 0;

  ling_serial_addsub #(.N(8)) u_dut8 (
    .CLOCK_50 (clk),   .RESET_N (rst_n),
    .in_valid (iv8),   .in_ready (ir8),   .op_sub (op8),
    .A (a8), .B (b8),
    .out_valid (ov8),  .out_ready (ordy8),
    .D (d8), .cout (co8), .borrow (bo8), .zero (ze8), .ovf (ovf8), .lt (lt8)
  );

  ling_serial_addsub #(.N(10)) u_dut10 (
    .CLOCK_50 (clk),   .RESET_N (rst_n),
    .in_valid (iv10),  .in_ready (ir10),  .op_sub (op10),
    .A (a10), .B (b10),
    .out_valid (ov10), .out_ready (ordy10),
    .D (d10), .cout (co10), .borrow (bo10), .zero (ze10), .ovf (ovf10), .lt (lt10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on n-bit values.
  task automatic model(input int n, input int a, input int b, input bit op,
                       output int d, output int co, output int bo, output int ze,
                       output int ovf, output int lt);
    int mask, bm, sum, sa, sb, res;
    mask = (1 << n) - 1;
    a    = a & mask;
    b    = b & mask;
    bm   = op ? (~b & mask) : b;
    sum  = a + bm + int'(op);
    d    = sum & mask;
    co   = (sum >> n) & 1;
    bo   = (op && (a < b)) ? 1 : 0;
    ze   = (d == 0) ? 1 : 0;
    sa   = (a >= (1 << (n - 1))) ? a - (1 << n) : a;
    sb   = (b >= (1 << (n - 1))) ? b - (1 << n) : b;
    res  = op ? sa - sb : sa + sb;
`ifdef LING_ADDSUB_FLAGS_EN
    ovf  = (res < -(1 << (n - 1)) || res > (1 << (n - 1)) - 1) ? 1 : 0;
    lt   = (op && (sa < sb)) ? 1 : 0;
`else
    ovf  = (res == res) ? 0 : 0;
    lt   = 0;
`endif
  endtask

  task automatic drive(input int which, input bit v, input bit op, input int a,
                       input int b, input bit ordy);
    if (which != 0) begin
      iv10 = v; op10 = op; a10 = a[9:0]; b10 = b[9:0]; ordy10 = ordy;
    end else begin
      iv8 = v;  op8 = op;  a8 = a[7:0];  b8 = b[7:0];  ordy8 = ordy;
    end
  endtask

  task automatic sample(input int which, output logic ov, output logic ir,
                        output logic [31:0] d, output logic [31:0] flags);
    if (which != 0) begin
      ov = ov10; ir = ir10; d = {22'b0, d10};
      flags = {27'b0, co10, bo10, ze10, ovf10, lt10};
    end else begin
      ov = ov8; ir = ir8; d = {24'b0, d8};
      flags = {27'b0, co8, bo8, ze8, ovf8, lt8};
    end
  endtask

  // One full transaction: accept, scramble inputs, wait for the result,
  // hold it under backpressure for `hold` cycles, then release.
  task automatic run_op(input int which, input int a_in, input int b_in,
                        input bit op, input int hold);
    int n, nb, mask, a, b, ed, eco, ebo, eze, eovf, elt, edges;
    logic ov, ir;
    logic [31:0] d, flags, eflags;
    n    = (which != 0) ? 10 : 8;
    nb   = (n + 3) / 4;
    mask = (1 << n) - 1;
    a    = a_in & mask;
    b    = b_in & mask;
    model(n, a, b, op, ed, eco, ebo, eze, eovf, elt);
    eflags = {27'b0, eco[0], ebo[0], eze[0], eovf[0], elt[0]};

    @(negedge clk);
    drive(which, 1'b1, op, a, b, 1'b0);
    sample(which, ov, ir, d, flags);
    check("in_ready_idle", {31'b0, ir}, 32'd1);
    @(posedge clk);                       // accept edge
    @(negedge clk);
    // Operands are sampled on the accept edge only.
    drive(which, 1'b0, ~op, int'($urandom), int'($urandom), 1'b0);
    sample(which, ov, ir, d, flags);
    check("in_ready_busy", {31'b0, ir}, 32'd0);
    edges = 0;
    while (!ov && edges < 20) begin
      @(negedge clk);
      edges++;
      sample(which, ov, ir, d, flags);
    end
    // Accept cycle is cycle 0; out_valid first seen in cycle NB+1.
    check("latency_cycles", edges + 1, nb + 1);
    check("result_D", d, ed);
    check("flags_co_bo_ze_ovf_lt", flags, eflags);

    for (int h = 0; h < hold; h++) begin
      drive(which, (h == 1), op, int'($urandom), int'($urandom), 1'b0);
      @(negedge clk);
      sample(which, ov, ir, d, flags);
      check("hold_valid", {31'b0, ov}, 32'd1);
      check("hold_in_ready", {31'b0, ir}, 32'd0);
      check("hold_D", d, ed);
      check("hold_flags", flags, eflags);
    end

    drive(which, 1'b0, 1'b0, 0, 0, 1'b1);
    @(negedge clk);
    sample(which, ov, ir, d, flags);
    check("release_valid", {31'b0, ov}, 32'd0);
    check("release_in_ready", {31'b0, ir}, 32'd1);
    drive(which, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    logic ov, ir;
    logic [31:0] d, flags;

    drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0);
    rst_n = 1'b0;
    #12;
    for (int w = 0; w < 2; w++) begin
      sample(w, ov, ir, d, flags);
      check("reset_valid", {31'b0, ov}, 32'd0);
      check("reset_in_ready", {31'b0, ir}, 32'd1);
      check("reset_D", d, 32'd0);
      check("reset_flags", flags, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(0, 'h05, 'h03, 1'b1, 0);
    run_op(0, 'h03, 'h05, 1'b1, 0);
    run_op(0, 'hFF, 'h01, 1'b0, 0);
    run_op(0, 'h80, 'h01, 1'b1, 0);
    run_op(0, 'h7F, 'h01, 1'b0, 0);
    run_op(1, 'h3FF, 'h001, 1'b0, 0);
    run_op(1, 'h200, 'h001, 1'b1, 0);
    run_op(1, 'h000, 'h000, 1'b1, 0);

    // Backpressure with an ignored in_valid pulse.
    run_op(0, 'hA5, 'h3C, 1'b1, 5);
    run_op(1, 'h155, 'h2AA, 1'b0, 5);

    // Reset during the second RUN cycle.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 'h12, 'h34, 1'b0);
    @(posedge clk);                       // accept
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);                       // first RUN edge
    @(negedge clk);                       // inside second RUN cycle
    rst_n = 1'b0;
    #1;
    sample(0, ov, ir, d, flags);
    check("midrun_reset_valid", {31'b0, ov}, 32'd0);
    check("midrun_reset_in_ready", {31'b0, ir}, 32'd1);
    check("midrun_reset_D", d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sample(0, ov, ir, d, flags);
      check("after_reset_no_output", {31'b0, ov}, 32'd0);
    end
    run_op(0, 'h12, 'h34, 1'b0, 0);

    // Random traffic on both widths.
    for (int i = 0; i < 40; i++) begin
      run_op(i % 2, int'($urandom), int'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
